// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - multicycle MIPS control FSM (optional CTRL_PERF_COUNT_EN retired-instruction counter)
module unidad_control_multiciclo #(
    parameter int OPW  = 6,
    parameter int AOPW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  op_code,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            ir_write,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [AOPW-1:0] alu_op,
    output logic            pc_source,
    output logic            illegal_op,
    output logic [3:0]      state
`ifdef CTRL_PERF_COUNT_EN
    ,
    output logic [31:0]     instr_count
`endif
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        EXEC_I   = 4'd9,
        I_WB     = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPW-1:0] OP_ORI   = 6'b001101;

    localparam logic [AOPW-1:0] ALU_ADD   = 3'b000;
    localparam logic [AOPW-1:0] ALU_SUB   = 3'b001;
    localparam logic [AOPW-1:0] ALU_SLT   = 3'b010;
    localparam logic [AOPW-1:0] ALU_AND   = 3'b101;
    localparam logic [AOPW-1:0] ALU_OR    = 3'b110;
    localparam logic [AOPW-1:0] ALU_FUNCT = 3'b111;

    state_t          r_state;
    state_t          w_next;
    logic [AOPW-1:0] w_imm_alu_op;

    assign state = r_state;

    // Immediate-class ALU operation; IR is stable after FETCH so EXEC_I and I_WB agree.
    always_comb begin
        w_imm_alu_op = ALU_ADD;
        case (op_code)
            OP_ANDI: w_imm_alu_op = ALU_AND;
            OP_SLTI: w_imm_alu_op = ALU_SLT;
            OP_ORI:  w_imm_alu_op = ALU_OR;
            default: w_imm_alu_op = ALU_ADD;
        endcase
    end

    // State register; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs; everything is forced low while reset is held.
    always_comb begin
        w_next     = r_state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        pc_source  = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) w_next = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (op_code)
                    OP_RTYPE:                         w_next = EXEC_R;
                    OP_LW, OP_SW:                     w_next = MEM_ADDR;
                    OP_BEQ:                           w_next = BRANCH;
                    OP_ADDI, OP_ANDI, OP_SLTI, OP_ORI: w_next = EXEC_I;
                    default:                          w_next = TRAP;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = (op_code == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) w_next = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) w_next = FETCH;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                w_next    = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 1'b1;
                pc_write  = zero;
                w_next    = FETCH;
            end
            EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = w_imm_alu_op;
                w_next    = I_WB;
            end
            I_WB: begin
                reg_write = 1'b1;
                alu_op    = w_imm_alu_op;
                w_next    = FETCH;
            end
            TRAP: begin
                illegal_op = 1'b1;
                w_next     = TRAP;
            end
            default: w_next = FETCH;
        endcase
        if (!rst_n) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            reg_dst    = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = ALU_ADD;
            pc_source  = 1'b0;
            illegal_op = 1'b0;
        end
    end

`ifdef CTRL_PERF_COUNT_EN
    logic [31:0] r_instr_count;
    logic        w_retire;

    assign w_retire = (w_next == FETCH) &&
                      ((r_state == MEM_WB) || (r_state == MEM_WR) || (r_state == R_WB) ||
                       (r_state == BRANCH) || (r_state == I_WB));
    assign instr_count = r_instr_count;

    // Retired-instruction counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= 32'd0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/unidad_control_multiciclo.md
Name: unidad_control_multiciclo

Overview:
- Moore-style FSM that sequences the shared multicycle MIPS datapath: single ALU, single memory port, IR, ALUOut, MDR.
- Replaces per-instruction combinational decode with a fetch/decode/execute/memory/writeback schedule.
- Supports R-type, LW, SW, BEQ, ADDI, ANDI, SLTI and ORI.
- Waits on a memory ready handshake and traps on unknown opcodes.

Parameters:
- OPW, 6, opcode width.
- AOPW, 3, alu_op width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_code  in  6  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag, combinational from the datapath.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_to_reg  out  1  writeback source: 0=ALUOut, 1=MDR.
- reg_dst  out  1  destination register: 0=rt, 1=rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B input: 00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2.
- alu_op  out  3  000 add, 001 sub, 010 slt, 101 and, 110 or, 111 decode funct.
- pc_source  out  1  PC source: 0=ALU result, 1=ALUOut.
- illegal_op  out  1  sticky trap flag.
- state  out  4  current state, for debug.

Behaviour:
- Reset: async, rst_n=0 forces state=FETCH (0), illegal_op=0. All enables and requests (pc_write, ir_write, mem_read, mem_write, reg_write) are forced to 0 while rst_n=0. Every other output is 0 during reset.
- Outputs are decoded from state. pc_write and ir_write are additionally qualified by mem_ready or zero, as listed below.
- Any output not listed for a state is 0.

State encodings:
- FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, EXEC_I=9, I_WB=10, TRAP=11.

Per-state outputs and transitions:
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=0. ir_write=pc_write=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target latched into ALUOut).
  - op 000000 -> EXEC_R
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 001000, 001100, 001010, 001101 -> EXEC_I
  - anything else -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Go to MEM_RD if LW, MEM_WR if SW.
- MEM_RD: mem_read=1, i_or_d=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Wait for mem_ready, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=111. Then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=1, pc_write=zero. Then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10. alu_op is 000 for ADDI, 101 for ANDI, 010 for SLTI, 110 for ORI. Then I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. alu_op is held at the EXEC_I value. Then FETCH.
- TRAP: illegal_op=1, no enables asserted. Stays in TRAP until reset.

Latency with mem_ready=1 every cycle:
- BEQ 3 cycles; SW, R-type and I-type 4 cycles; LW 5 cycles.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.

Boundary conditions:
- mem_read and mem_write are never asserted together.
- Requests are held stable while waiting on mem_ready.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- Reset asserted mid-instruction aborts it: state goes to FETCH and no partial writeback occurs.
- zero is sampled only in BRANCH.
- op_code changes after DECODE are ignored, except for the LW/SW choice in MEM_ADDR and the alu_op select in EXEC_I/I_WB, which rely on IR being stable (IR is written only in FETCH).

Optional Feature:
- Macro: CTRL_PERF_COUNT_EN.
- Defined:
  - Adds output instr_count (32 bits).
  - Cleared by reset.
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH or I_WB, i.e. each retired instruction.
  - Wraps from 0xFFFFFFFF to 0.
  - Does not count in TRAP.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset/fetch: rst_n low for 2 cycles, release with mem_ready=0 for 3 cycles then 1 -> state=0 and mem_read=1 for 4 cycles; ir_write=pc_write=1 only on the 4th; DECODE follows.
- LW: op_code=100011, mem_ready=1 -> states 0,1,2,3,4,0; in MEM_WB, reg_write=1, mem_to_reg=1, reg_dst=0; 5 cycles total.
- SW with stall: op_code=101011, mem_ready=0 for 2 cycles in MEM_WR -> mem_write=1 held for 3 cycles, i_or_d=1, reg_write never 1.
- BEQ: op_code=000100 with zero=1 -> pc_write=1, pc_source=1 in BRANCH. Repeat with zero=0 -> pc_write=0. Both take 3 cycles.
- I-type: ADDI, ANDI, SLTI, ORI -> alu_op 000, 101, 010, 110 respectively in EXEC_I, alu_src_b=10; reg_write=1 in I_WB. R-type -> alu_op=111, reg_dst=1.
- Trap and reset mid-op: op_code=111111 -> TRAP, illegal_op=1, stays 10 cycles. Reset asserted during EXEC_R -> state=0 immediately and reg_write never asserted.
